// File: rtl/shl_issue_fifo_pkg.sv
// Shared definitions for the shift-operand issue stages: default widths,
// count/pointer sizing and the shift-amount clamp.
package shl_issue_fifo_pkg;

  localparam int SHL_DATAWIDTH = 8;
  localparam int SHL_DEPTH     = 4;

  function automatic int shl_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Returns {ovf, clamped}; the clamped amount saturates at the operand width.
  function automatic logic [32:0] shl_clamp(input logic [31:0] sh_amt,
                                            input logic [31:0] width);
    logic ovf;
    ovf = (sh_amt >= width);
    return {ovf, (ovf ? width : sh_amt)};
  endfunction

endpackage

// File: rtl/shl_fifo_mem.sv
// Entry storage for the issue FIFO: one synchronous write port and one
// combinational read port.
module shl_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/shl_issue_fifo.sv
// Operand issue stage for the SHL unit: queues (a, sh_amt) pairs, clamps the
// shift amount on entry and presents one registered pair at a time.
module shl_issue_fifo
  import shl_issue_fifo_pkg::*;
#(
  parameter int DATAWIDTH = SHL_DATAWIDTH,
  parameter int DEPTH     = SHL_DEPTH
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATAWIDTH-1:0]              a,
  input  logic [DATAWIDTH-1:0]              sh_amt,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATAWIDTH-1:0]              a_o,
  output logic [DATAWIDTH-1:0]              sh_amt_o,
  output logic                              ovf_o,
  output logic [shl_cnt_width(DEPTH)-1:0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = shl_cnt_width(DEPTH);
  localparam int ENTRY_W = 2 * DATAWIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [DATAWIDTH-1:0] r_a;
  logic [DATAWIDTH-1:0] r_sh;
  logic                 r_ovf;

  logic                 w_push;
  logic                 w_pop;
  logic [DATAWIDTH-1:0] w_in_sh;
  logic                 w_in_ovf;
  logic [ENTRY_W-1:0]   w_in_entry;
  logic [ENTRY_W-1:0]   w_mem_entry;
  logic [ENTRY_W-1:0]   w_next_entry;
  logic [CNT_W-1:0]     w_next_count;
  logic                 w_load_mem;
  logic                 w_load;

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  assign w_in_sh    = DATAWIDTH'(shl_clamp(32'(sh_amt), 32'(DATAWIDTH)));
  assign w_in_ovf   = 1'(shl_clamp(32'(sh_amt), 32'(DATAWIDTH)) >> 32);
  assign w_in_entry = {w_in_ovf, w_in_sh, a};

  // The memory holds every entry including the presented head at r_rd_ptr,
  // so the successor read here is what a pop exposes next.
  shl_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .i_clk   (Clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_in_entry),
    .i_raddr (r_rd_ptr + PTR_W'(1)),
    .o_rdata (w_mem_entry)
  );

  // A lone entry being popped alongside a push has no stored successor yet,
  // so the incoming pair is bypassed straight into the output registers.
  assign w_load_mem   = w_pop && (r_count > ONE_CNT);
  assign w_load       = w_load_mem || (w_push && (w_pop || (r_count == ZERO_CNT)));
  assign w_next_entry = w_load_mem ? w_mem_entry : w_in_entry;

  always_comb begin
    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + ONE_CNT;
      2'b01:   w_next_count = r_count - ONE_CNT;
      default: w_next_count = r_count;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= ZERO_CNT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_sh        <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count     <= w_next_count;
      r_in_ready  <= (w_next_count < FULL_CNT);
      r_out_valid <= (w_next_count != ZERO_CNT);
      if (w_load) begin
        {r_ovf, r_sh, r_a} <= w_next_entry;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign a_o       = r_a;
  assign sh_amt_o  = r_sh;
  assign ovf_o     = r_ovf;
  assign count     = r_count;

endmodule

// File: tb/tb_shl_issue_fifo.sv
// Directed bench for shl_issue_fifo with a behavioural SHL on the outputs.
module tb_shl_issue_fifo;

  logic       Clk;
  logic       Rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] sh_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a_o;
  logic [7:0] sh_amt_o;
  logic       ovf_o;
  logic [2:0] count;
  logic [7:0] d;

  int n_checks = 0;
  int n_errors = 0;

  shl_issue_fifo #(.DATAWIDTH(8), .DEPTH(4)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .sh_amt    (sh_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_o       (a_o),
    .sh_amt_o  (sh_amt_o),
    .ovf_o     (ovf_o),
    .count     (count)
  );

  // Downstream SHL datapath model.
  assign d = a_o << sh_amt_o;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int exp_drain [5] = '{1, 2, 3, 4, 6};

  initial begin
    Rst = 1'b1; in_valid = 1'b0; a = 8'd0; sh_amt = 8'd0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_a_o", 32'(a_o), 32'd0);
    tick();
    Rst = 1'b0;
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic pass-through.
    in_valid = 1'b1; a = 8'd20; sh_amt = 8'd1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_a_o", 32'(a_o), 32'd20);
    check("pt_sh", 32'(sh_amt_o), 32'd1);
    check("pt_ovf", 32'(ovf_o), 32'd0);
    check("pt_d", 32'(d), 32'd40);
    check("pt_count1", 32'(count), 32'd1);
    tick();
    check("pt_count0", 32'(count), 32'd0);
    check("pt_empty", 32'(out_valid), 32'd0);

    // Clamp above and at the operand width.
    in_valid = 1'b1; a = 8'd40; sh_amt = 8'd9;
    tick();
    in_valid = 1'b0;
    check("cl9_sh", 32'(sh_amt_o), 32'd8);
    check("cl9_ovf", 32'(ovf_o), 32'd1);
    check("cl9_d", 32'(d), 32'd0);
    tick();
    in_valid = 1'b1; a = 8'd40; sh_amt = 8'd8;
    tick();
    in_valid = 1'b0;
    check("cl8_sh", 32'(sh_amt_o), 32'd8);
    check("cl8_ovf", 32'(ovf_o), 32'd1);
    tick();
    check("cl_count0", 32'(count), 32'd0);

    // Fill and backpressure: only four of five pushes fit.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; a = 8'(i); sh_amt = 8'd3;
      check($sformatf("fill_ready_%0d", i), 32'(in_ready), (i <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_a_o", 32'(a_o), 32'd1);
    check("full_sh", 32'(sh_amt_o), 32'd3);
    tick();
    tick();
    check("hold_a_o", 32'(a_o), 32'd1);
    check("hold_valid", 32'(out_valid), 32'd1);

    // Drain while full with a pending push.
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd6; sh_amt = 8'd2;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("drain_a_o_%0d", k), 32'(a_o), 32'(exp_drain[k]));
      if (k == 0) check("drain_refused", 32'(in_ready), 32'd0);
      if (k == 1) check("drain_accept", 32'(in_ready), 32'd1);
      tick();
      if (k == 1) in_valid = 1'b0;
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Streaming one pair per cycle.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 8'(i); sh_amt = 8'(i % 4);
      tick();
      check($sformatf("str_a_o_%0d", i), 32'(a_o), 32'(i));
      check($sformatf("str_sh_%0d", i), 32'(sh_amt_o), 32'(i % 4));
      check($sformatf("str_count_%0d", i), 32'(count), 32'd1);
      check($sformatf("str_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("str_count0", 32'(count), 32'd0);

    // Asynchronous reset with three entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 8'(7 + i); sh_amt = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    #2;
    Rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_a_o", 32'(a_o), 32'd0);
    check("arst_sh", 32'(sh_amt_o), 32'd0);
    check("arst_ovf", 32'(ovf_o), 32'd0);
    tick();
    Rst = 1'b0;
    tick();
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_count", 32'(count), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = 8'h55; sh_amt = 8'd10; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_a_o", 32'(a_o), 32'h55);
    check("post_sh", 32'(sh_amt_o), 32'd8);
    check("post_ovf", 32'(ovf_o), 32'd1);
    check("post_count1", 32'(count), 32'd1);
    tick();
    check("post_drain_valid", 32'(out_valid), 32'd0);
    check("post_drain_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
